// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared state encoding and synchronizer depth for the SPI slave.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int SPI_SYNC_STAGES = 2;

    typedef enum logic [0:0] {
        SPI_S_IDLE   = 1'b0,
        SPI_S_ACTIVE = 1'b1
    } spi_state_e;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Single-bit flop chain synchronizer, async active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff
    import spi_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SPI_SYNC_STAGES-1:0] r_sync_q;
    logic [SPI_SYNC_STAGES-1:0] w_sync_d;

    always_comb begin
        w_sync_d = {r_sync_q[SPI_SYNC_STAGES-2:0], d};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync_q <= '0;
        end else begin
            r_sync_q <= w_sync_d;
        end
    end

    assign q = r_sync_q[SPI_SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave
// Description : Mode-0 MSB-first SPI responder, oversampled in the clk domain.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave
    import spi_pkg::*;
#(
    parameter int                   BIT_WIDTH    = 8,
    parameter logic [BIT_WIDTH-1:0] TX_IDLE_DATA = '0
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sck,
    input  logic                 ssel,
    input  logic                 mosi,
    output logic                 miso,
    output logic                 miso_oe,
    output logic                 busy,
    output logic                 rx_data_tick,
    output logic [BIT_WIDTH-1:0] rx_data,
    input  logic                 tx_data_tick,
    input  logic [BIT_WIDTH-1:0] tx_data,
    output logic                 tx_pending,
    output logic                 frame_error
);

    localparam int CNT_W = $clog2(BIT_WIDTH);

    logic w_sck_s;
    logic w_ssel_s;
    logic w_mosi_s;

    sync_2ff u_sync_sck  (.clk(clk), .reset(reset), .d(sck),  .q(w_sck_s));
    sync_2ff u_sync_ssel (.clk(clk), .reset(reset), .d(ssel), .q(w_ssel_s));
    sync_2ff u_sync_mosi (.clk(clk), .reset(reset), .d(mosi), .q(w_mosi_s));

    spi_state_e           r_state_q,      w_state_d;
    logic [CNT_W-1:0]     r_bitcnt_q,     w_bitcnt_d;
    logic [BIT_WIDTH-1:0] r_rx_shift_q,   w_rx_shift_d;
    logic [BIT_WIDTH-1:0] r_tx_shift_q,   w_tx_shift_d;
    logic [BIT_WIDTH-1:0] r_tx_buf_q,     w_tx_buf_d;
    logic [BIT_WIDTH-1:0] r_rx_data_q,    w_rx_data_d;
    logic                 r_tx_pending_q, w_tx_pending_d;
    logic                 r_reload_q,     w_reload_d;
    logic                 r_rx_tick_q,    w_rx_tick_d;
    logic                 r_frame_err_q,  w_frame_err_d;
    logic                 r_sck_prev_q;
    logic                 r_ssel_prev_q;

    logic                 w_sck_rise;
    logic                 w_sck_fall;
    logic                 w_ssel_fall;
    logic                 w_ssel_rise;
    logic                 w_load;
    logic [BIT_WIDTH-1:0] w_rx_next;

    assign w_sck_rise  =  w_sck_s  & ~r_sck_prev_q;
    assign w_sck_fall  = ~w_sck_s  &  r_sck_prev_q;
    assign w_ssel_fall = ~w_ssel_s &  r_ssel_prev_q;
    assign w_ssel_rise =  w_ssel_s & ~r_ssel_prev_q;

    always_comb begin
        w_state_d      = r_state_q;
        w_bitcnt_d     = r_bitcnt_q;
        w_rx_shift_d   = r_rx_shift_q;
        w_tx_shift_d   = r_tx_shift_q;
        w_tx_buf_d     = r_tx_buf_q;
        w_rx_data_d    = r_rx_data_q;
        w_tx_pending_d = r_tx_pending_q;
        w_reload_d     = r_reload_q;
        w_rx_tick_d    = 1'b0;
        w_frame_err_d  = 1'b0;
        w_load         = 1'b0;
        w_rx_next      = {r_rx_shift_q[BIT_WIDTH-2:0], w_mosi_s};

        case (r_state_q)
            SPI_S_IDLE: begin
                if (w_ssel_fall) begin
                    w_state_d  = SPI_S_ACTIVE;
                    w_load     = 1'b1;
                    w_bitcnt_d = '0;
                    w_reload_d = 1'b0;
                end
            end
            SPI_S_ACTIVE: begin
                // ssel is checked first so a coincident sck event is dropped
                if (w_ssel_rise) begin
                    w_state_d     = SPI_S_IDLE;
                    w_frame_err_d = (r_bitcnt_q != '0);
                    w_bitcnt_d    = '0;
                    w_reload_d    = 1'b0;
                end else if (w_sck_rise) begin
                    w_rx_shift_d = w_rx_next;
                    if (r_bitcnt_q == CNT_W'(BIT_WIDTH - 1)) begin
                        w_rx_data_d = w_rx_next;
                        w_rx_tick_d = 1'b1;
                        w_bitcnt_d  = '0;
                        w_reload_d  = 1'b1;
                    end else begin
                        w_bitcnt_d = r_bitcnt_q + CNT_W'(1);
                    end
                end else if (w_sck_fall) begin
                    if (r_reload_q) begin
                        w_load     = 1'b1;
                        w_reload_d = 1'b0;
                    end else begin
                        w_tx_shift_d = {r_tx_shift_q[BIT_WIDTH-2:0], 1'b0};
                    end
                end
            end
            default: w_state_d = SPI_S_IDLE;
        endcase

        // A host tick landing on a load cycle goes straight to the shifter
        if (w_load) begin
            if (tx_data_tick) begin
                w_tx_shift_d = tx_data;
            end else if (r_tx_pending_q) begin
                w_tx_shift_d = r_tx_buf_q;
            end else begin
                w_tx_shift_d = TX_IDLE_DATA;
            end
            w_tx_pending_d = 1'b0;
        end else if (tx_data_tick) begin
            w_tx_buf_d     = tx_data;
            w_tx_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q      <= SPI_S_IDLE;
            r_bitcnt_q     <= '0;
            r_rx_shift_q   <= '0;
            r_tx_shift_q   <= '0;
            r_tx_buf_q     <= '0;
            r_rx_data_q    <= '0;
            r_tx_pending_q <= 1'b0;
            r_reload_q     <= 1'b0;
            r_rx_tick_q    <= 1'b0;
            r_frame_err_q  <= 1'b0;
            r_sck_prev_q   <= 1'b0;
            r_ssel_prev_q  <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_bitcnt_q     <= w_bitcnt_d;
            r_rx_shift_q   <= w_rx_shift_d;
            r_tx_shift_q   <= w_tx_shift_d;
            r_tx_buf_q     <= w_tx_buf_d;
            r_rx_data_q    <= w_rx_data_d;
            r_tx_pending_q <= w_tx_pending_d;
            r_reload_q     <= w_reload_d;
            r_rx_tick_q    <= w_rx_tick_d;
            r_frame_err_q  <= w_frame_err_d;
            r_sck_prev_q   <= w_sck_s;
            r_ssel_prev_q  <= w_ssel_s;
        end
    end

    assign miso         = r_tx_shift_q[BIT_WIDTH-1];
    assign busy         = (r_state_q == SPI_S_ACTIVE);
    assign miso_oe      = (r_state_q == SPI_S_ACTIVE);
    assign rx_data_tick = r_rx_tick_q;
    assign rx_data      = r_rx_data_q;
    assign tx_pending   = r_tx_pending_q;
    assign frame_error  = r_frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave
// Description : Scoreboard bench for spi_slave with a behavioural SPI master.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave;

    logic       clk;
    logic       reset;
    logic       sck;
    logic       ssel;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic       busy;
    logic       rx_data_tick;
    logic [7:0] rx_data;
    logic       tx_data_tick;
    logic [7:0] tx_data;
    logic       tx_pending;
    logic       frame_error;

    spi_slave #(.BIT_WIDTH(8), .TX_IDLE_DATA(8'h00)) dut (
        .clk         (clk),
        .reset       (reset),
        .sck         (sck),
        .ssel        (ssel),
        .mosi        (mosi),
        .miso        (miso),
        .miso_oe     (miso_oe),
        .busy        (busy),
        .rx_data_tick(rx_data_tick),
        .rx_data     (rx_data),
        .tx_data_tick(tx_data_tick),
        .tx_data     (tx_data),
        .tx_pending  (tx_pending),
        .frame_error (frame_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_rx_q[$];
    logic [7:0] exp_miso_q[$];
    int         exp_fe_q[$];

    logic       model_pending = 1'b0;
    logic [7:0] model_buf     = 8'h00;

    logic [7:0] f_mosi[0:3];
    int         f_load[0:3];

    logic [7:0] mst_rx;
    event       mst_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_take();
        logic [7:0] v;
        v = model_pending ? model_buf : 8'h00;
        model_pending = 1'b0;
        return v;
    endfunction

    // One-clk host write; called at posedge+2
    task automatic host_load(input logic [7:0] v);
        tx_data      = v;
        tx_data_tick = 1'b1;
        #10;
        tx_data_tick = 1'b0;
        model_buf     = v;
        model_pending = 1'b1;
    endtask

    // Frame of nmsg messages; the last one is cut after nbits_last bits.
    // bypass >= 0 puts a host write on the same clk as the select load.
    task automatic do_frame(input int nmsg, input int nbits_last, input int bypass);
        logic [7:0] v;
        logic [7:0] rx;
        int         nb;
        mosi = f_mosi[0][7];
        ssel = 1'b0;
        if (bypass >= 0) begin
            #20;
            tx_data      = 8'(bypass);
            tx_data_tick = 1'b1;
            #10;
            tx_data_tick = 1'b0;
            #20;
            v = 8'(bypass);
            model_pending = 1'b0;
        end else begin
            v = model_take();
            #50;
        end
        for (int m = 0; m < nmsg; m++) begin
            nb = (m == nmsg - 1) ? nbits_last : 8;
            if (nb == 8) begin
                exp_rx_q.push_back(f_mosi[m]);
                exp_miso_q.push_back(v);
            end else begin
                exp_fe_q.push_back(1);
            end
            rx = 8'h00;
            for (int b = 0; b < nb; b++) begin
                sck = 1'b1;
                rx  = {rx[6:0], miso};
                if (b == 0) begin
                    chk("busy_in_frame", busy, 1);
                    chk("miso_oe_in_frame", miso_oe, 1);
                end
                if (b == 7 && f_load[m] >= 0) begin
                    #40;
                    host_load(8'(f_load[m]));
                end else begin
                    #50;
                end
                sck = 1'b0;
                if (b < 7)
                    mosi = f_mosi[m][6 - b];
                else if (m + 1 < nmsg)
                    mosi = f_mosi[m + 1][7];
                #50;
            end
            if (nb == 8) begin
                mst_rx = rx;
                ->mst_done;
                v = model_take();
            end
        end
        ssel = 1'b1;
        #100;
        chk("busy_after_frame", busy, 0);
        chk("tx_pending_after_frame", tx_pending, model_pending);
    endtask

    // Slave-side output monitor: ticks, pulse widths and rx_data stability
    initial begin
        logic [7:0] last_rx;
        int         tick_run;
        int         fe_run;
        last_rx  = 8'h00;
        tick_run = 0;
        fe_run   = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                last_rx  = 8'h00;
                tick_run = 0;
                fe_run   = 0;
            end else begin
                if (rx_data_tick) begin
                    if (tick_run == 0) begin
                        chk("rx_tick_expected", exp_rx_q.size() > 0, 1);
                        if (exp_rx_q.size() > 0)
                            chk("slave_rx_data", rx_data, exp_rx_q.pop_front());
                    end
                    tick_run++;
                    last_rx = rx_data;
                end else begin
                    if (tick_run != 0)
                        chk("rx_tick_width", tick_run, 1);
                    tick_run = 0;
                    if (rx_data !== last_rx)
                        chk("rx_data_stable", rx_data, last_rx);
                end
                if (frame_error) begin
                    if (fe_run == 0) begin
                        chk("frame_error_expected", exp_fe_q.size() > 0, 1);
                        if (exp_fe_q.size() > 0)
                            void'(exp_fe_q.pop_front());
                    end
                    fe_run++;
                end else begin
                    if (fe_run != 0)
                        chk("frame_error_width", fe_run, 1);
                    fe_run = 0;
                end
            end
        end
    end

    // Master-side monitor: bytes the master shifted in from miso
    initial begin
        forever begin
            @(mst_done);
            chk("miso_expected", exp_miso_q.size() > 0, 1);
            if (exp_miso_q.size() > 0)
                chk("master_rx_data", mst_rx, exp_miso_q.pop_front());
        end
    end

    initial begin
        int nm;
        int nb;
        int byp;
        reset        = 1'b1;
        sck          = 1'b0;
        ssel         = 1'b1;
        mosi         = 1'b0;
        tx_data_tick = 1'b0;
        tx_data      = 8'h00;
        for (int m = 0; m < 4; m++) begin
            f_mosi[m] = 8'h00;
            f_load[m] = -1;
        end
        repeat (3) @(posedge clk);
        #2;
        chk("rst_miso", miso, 0);
        chk("rst_miso_oe", miso_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rx_data_tick", rx_data_tick, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_tx_pending", tx_pending, 0);
        chk("rst_frame_error", frame_error, 0);
        reset = 1'b0;
        #100;

        // 1: loaded buffer, single message
        host_load(8'hA5);
        #10;
        chk("tx_pending_after_load", tx_pending, 1);
        f_mosi[0] = 8'h3C;
        do_frame(1, 8, -1);

        // 2: nothing loaded, idle pattern out
        f_mosi[0] = 8'hFF;
        do_frame(1, 8, -1);

        // 3: two messages in one frame, reload between them
        host_load(8'hA5);
        f_mosi[0] = 8'h12;
        f_mosi[1] = 8'h34;
        f_load[0] = 8'h56;
        do_frame(2, 8, -1);
        f_load[0] = -1;

        // 4: abort after 5 bits, then a clean message
        f_mosi[0] = 8'hC3;
        do_frame(1, 5, -1);
        f_mosi[0] = 8'h5A;
        do_frame(1, 8, -1);

        // 5: host write coincident with the select load
        f_mosi[0] = 8'h81;
        do_frame(1, 8, 8'h77);

        // 6: reset mid-message
        host_load(8'h99);
        ssel = 1'b0;
        mosi = 1'b1;
        #50;
        for (int b = 0; b < 3; b++) begin
            sck = 1'b1;
            #50;
            sck = 1'b0;
            #50;
        end
        reset = 1'b1;
        #1;
        chk("rst2_miso", miso, 0);
        chk("rst2_miso_oe", miso_oe, 0);
        chk("rst2_busy", busy, 0);
        chk("rst2_rx_data", rx_data, 0);
        chk("rst2_tx_pending", tx_pending, 0);
        chk("rst2_frame_error", frame_error, 0);
        #29;
        reset = 1'b0;
        model_pending = 1'b0;
        #40;
        chk("no_entry_without_fall", busy, 0);
        ssel = 1'b1;
        #100;
        host_load(8'hE7);
        f_mosi[0] = 8'h6B;
        do_frame(1, 8, -1);

        // Randomized frames
        for (int k = 0; k < 25; k++) begin
            nm = int'($urandom_range(1, 3));
            for (int m = 0; m < 4; m++) begin
                f_mosi[m] = 8'($urandom);
                f_load[m] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 255)) : -1;
            end
            if ($urandom_range(0, 1) == 1)
                host_load(8'($urandom));
            nb  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 7)) : 8;
            byp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : -1;
            do_frame(nm, nb, byp);
        end

        #500;
        chk("rx_queue_drained", exp_rx_q.size(), 0);
        chk("miso_queue_drained", exp_miso_q.size(), 0);
        chk("fe_queue_drained", exp_fe_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
